// File: rtl/voice_pool_mixer_if.sv
// voice_pool_mixer_if
// Purpose: bundles the note-allocation and sample-mixing signals that run
//    between song_reader, the note_player voices, the mixer and the codec side.
// Signals:
//    beat                 48 Hz beat strobe
//    load_new_note        1-cycle strobe, note_to_load/duration_to_load valid
//    note_to_load         6-bit note index
//    duration_to_load     6-bit duration in beats
//    generate_next_sample codec sample request strobe
//    voice_playing        per-voice busy flags
//    voice_sample         packed voice samples, voice i at [i*SAMPLE_W +: SAMPLE_W]
//    voice_ready          per-voice sample-ready strobes
//    voice_load           one-hot 1-cycle load strobe towards the voices
//    voice_note           note that goes with voice_load
//    voice_duration       duration that goes with voice_load
//    note_dropped         1-cycle strobe, note discarded
//    active_voices        count of voices that are playing or reserved
//    sample_out           mixed sample, held between updates
//    new_sample_ready     1-cycle strobe, sample_out updated
// Modports: master drives the requests and voice status, slave is the mixer.

interface voice_pool_mixer_if #(
   parameter int NUM_VOICES = 4,
   parameter int SAMPLE_W   = 16
);
   localparam int ACT_W = $clog2(NUM_VOICES + 1);

   logic                           beat;
   logic                           load_new_note;
   logic [5:0]                     note_to_load;
   logic [5:0]                     duration_to_load;
   logic                           generate_next_sample;
   logic [NUM_VOICES-1:0]          voice_playing;
   logic [NUM_VOICES*SAMPLE_W-1:0] voice_sample;
   logic [NUM_VOICES-1:0]          voice_ready;
   logic [NUM_VOICES-1:0]          voice_load;
   logic [5:0]                     voice_note;
   logic [5:0]                     voice_duration;
   logic                           note_dropped;
   logic [ACT_W-1:0]               active_voices;
   logic [SAMPLE_W-1:0]            sample_out;
   logic                           new_sample_ready;

   modport master (
      output beat, load_new_note, note_to_load, duration_to_load,
             generate_next_sample, voice_playing, voice_sample, voice_ready,
      input  voice_load, voice_note, voice_duration, note_dropped,
             active_voices, sample_out, new_sample_ready
   );

   modport slave (
      input  beat, load_new_note, note_to_load, duration_to_load,
             generate_next_sample, voice_playing, voice_sample, voice_ready,
      output voice_load, voice_note, voice_duration, note_dropped,
             active_voices, sample_out, new_sample_ready
   );
endinterface

// File: rtl/voice_pool_mixer.sv
// voice_pool_mixer
// Purpose: hands each incoming note to a free note_player voice (or steals the
//    oldest one when all are busy), then on each codec request collects one
//    sample per voice and produces a scaled, saturated sum.
// Ports:
//    clk    system clock
//    reset  synchronous active-high reset
//    bus    voice_pool_mixer_if slave modport carrying all note, voice and
//           sample signals

module voice_pool_mixer #(
   parameter int NUM_VOICES = 4,
   parameter int SAMPLE_W   = 16,
   parameter int AGE_W      = 8,
   parameter int MIX_SHIFT  = 2,
   parameter int STEAL_EN   = 1,
   parameter int COLLECT_TO = 64
) (
   input logic               clk,
   input logic               reset,
   voice_pool_mixer_if.slave bus
);
   localparam int IDX_W = $clog2(NUM_VOICES);
   localparam int ACC_W = SAMPLE_W + $clog2(NUM_VOICES);
   localparam int CNT_W = $clog2(COLLECT_TO + 1);
   localparam int ACT_W = $clog2(NUM_VOICES + 1);
   localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, COLLECT, SUM, OUT} mixState_e;

   logic [NUM_VOICES-1:0]       voiceLoad_q;
   logic [5:0]                  voiceNote_q;
   logic [5:0]                  voiceDur_q;
   logic                        noteDropped_q;
   logic [NUM_VOICES-1:0]       reserved_q;
   logic [1:0]                  resCnt_q [NUM_VOICES];
   logic [AGE_W-1:0]            age_q [NUM_VOICES];

   logic [NUM_VOICES-1:0]       freeMask;
   logic                        freeFound;
   logic [IDX_W-1:0]            freeIdx;
   logic [IDX_W-1:0]            oldestIdx;
   logic [AGE_W-1:0]            oldestAge;
   logic [IDX_W-1:0]            target;
   logic                        serve;
   logic [ACT_W-1:0]            activeCount;

   mixState_e                   state_q, state_d;
   logic [NUM_VOICES-1:0]       mask_q, maskNext;
   logic [CNT_W-1:0]            cnt_q;
   logic [IDX_W-1:0]            idx_q;
   logic signed [ACC_W-1:0]     acc_q;
   logic signed [ACC_W-1:0]     shifted;
   logic signed [SAMPLE_W-1:0]  samp_q [NUM_VOICES];
   logic [SAMPLE_W-1:0]         sampleOut_q;
   logic [SAMPLE_W-1:0]         satSample;
   logic                        newSample_q;

   // Pick the allocation target: the lowest free voice if there is one,
   // otherwise the oldest voice (the strict '>' keeps the lowest index on ties).
   // Reserved voices count as busy so a note loaded last cycle is not reused
   // before its voice has reported playing.
   always_comb begin
      freeMask  = ~(bus.voice_playing | reserved_q);
      freeFound = 1'b0;
      freeIdx   = '0;
      for (int i = NUM_VOICES - 1; i >= 0; i--) begin
         if (freeMask[i]) begin
            freeFound = 1'b1;
            freeIdx   = IDX_W'(i);
         end
      end
      oldestIdx = '0;
      oldestAge = age_q[0];
      for (int i = 1; i < NUM_VOICES; i++) begin
         if (age_q[i] > oldestAge) begin
            oldestAge = age_q[i];
            oldestIdx = IDX_W'(i);
         end
      end
      target = freeFound ? freeIdx : oldestIdx;
      serve  = bus.load_new_note && (freeFound || (STEAL_EN != 0));
   end

   // Register the load strobe with its note and duration, or flag the note
   // as dropped when nothing can take it.
   always_ff @(posedge clk) begin
      if (reset) begin
         voiceLoad_q   <= '0;
         voiceNote_q   <= '0;
         voiceDur_q    <= '0;
         noteDropped_q <= 1'b0;
      end else begin
         voiceLoad_q   <= '0;
         noteDropped_q <= 1'b0;
         if (serve) begin
            voiceLoad_q <= {{(NUM_VOICES-1){1'b0}}, 1'b1} << target;
            voiceNote_q <= bus.note_to_load;
            voiceDur_q  <= bus.duration_to_load;
         end else if (bus.load_new_note) begin
            noteDropped_q <= 1'b1;
         end
      end
   end

   // Per-voice reservation and age tracking. A reservation lasts until the
   // voice reports playing or four cycles have gone by. Ages clear on the
   // same edge the load strobe is issued, so a load beats a concurrent beat.
   always_ff @(posedge clk) begin
      if (reset) begin
         reserved_q <= '0;
         for (int i = 0; i < NUM_VOICES; i++) begin
            resCnt_q[i] <= '0;
            age_q[i]    <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_VOICES; i++) begin
            if (serve && (target == IDX_W'(i))) begin
               reserved_q[i] <= 1'b1;
               resCnt_q[i]   <= '0;
               age_q[i]      <= '0;
            end else begin
               if (reserved_q[i]) begin
                  if (bus.voice_playing[i] || (resCnt_q[i] == 2'd3)) begin
                     reserved_q[i] <= 1'b0;
                  end else begin
                     resCnt_q[i] <= resCnt_q[i] + 2'd1;
                  end
               end
               if (bus.beat && bus.voice_playing[i] && (age_q[i] != '1)) begin
                  age_q[i] <= age_q[i] + AGE_W'(1);
               end
            end
         end
      end
   end

   // Occupancy count of voices that are either playing or reserved.
   always_comb begin
      activeCount = '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         activeCount = activeCount + ACT_W'(bus.voice_playing[i] | reserved_q[i]);
      end
   end

   // Mixer state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Mixer sequencing: collect until every voice has answered or the timeout
   // expires, add one voice per cycle, then publish the result.
   always_comb begin
      state_d  = state_q;
      maskNext = mask_q | bus.voice_ready;
      case (state_q)
         IDLE:    if (bus.generate_next_sample) state_d = COLLECT;
         COLLECT: if ((&maskNext) || (cnt_q == CNT_W'(COLLECT_TO - 1))) state_d = SUM;
         SUM:     if (idx_q == IDX_W'(NUM_VOICES - 1)) state_d = OUT;
         OUT:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Scale the wide sum and clamp it into the output sample range.
   always_comb begin
      shifted = acc_q >>> MIX_SHIFT;
      if (shifted > SAT_MAX) begin
         satSample = SAT_MAX[SAMPLE_W-1:0];
      end else if (shifted < SAT_MIN) begin
         satSample = SAT_MIN[SAMPLE_W-1:0];
      end else begin
         satSample = shifted[SAMPLE_W-1:0];
      end
   end

   // Mixer datapath. Voices that never answered are masked out of the sum,
   // so stale samples from an earlier request never leak into this one.
   always_ff @(posedge clk) begin
      if (reset) begin
         mask_q      <= '0;
         cnt_q       <= '0;
         idx_q       <= '0;
         acc_q       <= '0;
         sampleOut_q <= '0;
         newSample_q <= 1'b0;
         for (int i = 0; i < NUM_VOICES; i++) begin
            samp_q[i] <= '0;
         end
      end else begin
         newSample_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.generate_next_sample) begin
                  mask_q <= '0;
                  cnt_q  <= '0;
               end
            end
            COLLECT: begin
               mask_q <= maskNext;
               cnt_q  <= cnt_q + CNT_W'(1);
               for (int i = 0; i < NUM_VOICES; i++) begin
                  if (bus.voice_ready[i]) begin
                     samp_q[i] <= bus.voice_sample[i*SAMPLE_W +: SAMPLE_W];
                  end
               end
               if (state_d == SUM) begin
                  acc_q <= '0;
                  idx_q <= '0;
               end
            end
            SUM: begin
               if (mask_q[idx_q]) begin
                  acc_q <= acc_q + ACC_W'(samp_q[idx_q]);
               end
               idx_q <= idx_q + IDX_W'(1);
            end
            OUT: begin
               sampleOut_q <= satSample;
               newSample_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.voice_load       = voiceLoad_q;
   assign bus.voice_note       = voiceNote_q;
   assign bus.voice_duration   = voiceDur_q;
   assign bus.note_dropped     = noteDropped_q;
   assign bus.active_voices    = activeCount;
   assign bus.sample_out       = sampleOut_q;
   assign bus.new_sample_ready = newSample_q;
endmodule

// File: tb/tb_voice_pool_mixer.sv
// tb_voice_pool_mixer
// Purpose: directed self-checking bench for voice_pool_mixer. Two instances
//    share clock and reset: dutA steals voices and shifts the mix by 2, dutB
//    drops notes when full and applies no shift.

module tb_voice_pool_mixer;
   logic clk;
   logic reset;
   int   errors;
   int   checks;
   int   count;
   logic seen;

   voice_pool_mixer_if #(.NUM_VOICES(4), .SAMPLE_W(16)) busA ();
   voice_pool_mixer_if #(.NUM_VOICES(4), .SAMPLE_W(16)) busB ();

   voice_pool_mixer #(
      .NUM_VOICES(4), .SAMPLE_W(16), .AGE_W(8),
      .MIX_SHIFT(2), .STEAL_EN(1), .COLLECT_TO(64)
   ) dutA (
      .clk(clk), .reset(reset), .bus(busA.slave)
   );

   voice_pool_mixer #(
      .NUM_VOICES(4), .SAMPLE_W(16), .AGE_W(8),
      .MIX_SHIFT(0), .STEAL_EN(0), .COLLECT_TO(64)
   ) dutB (
      .clk(clk), .reset(reset), .bus(busB.slave)
   );

   // Free-running 100 MHz clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Backstop in case a bounded loop is mis-coded.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Advance one clock; outputs are then sampled 1 ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                              input logic signed [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Drive the note-side inputs of both instances identically.
   task automatic applyStimulus(input logic load, input logic [5:0] note,
                                input logic [5:0] dur, input logic [3:0] playing);
      busA.load_new_note    = load;
      busB.load_new_note    = load;
      busA.note_to_load     = note;
      busB.note_to_load     = note;
      busA.duration_to_load = dur;
      busB.duration_to_load = dur;
      busA.voice_playing    = playing;
      busB.voice_playing    = playing;
   endtask

   task automatic setBeat(input logic b);
      busA.beat = b;
      busB.beat = b;
   endtask

   task automatic setRequest(input logic g);
      busA.generate_next_sample = g;
      busB.generate_next_sample = g;
   endtask

   task automatic setSamples(input logic signed [15:0] s0, input logic signed [15:0] s1,
                             input logic signed [15:0] s2, input logic signed [15:0] s3);
      busA.voice_sample = {s3, s2, s1, s0};
      busB.voice_sample = {s3, s2, s1, s0};
   endtask

   task automatic setReady(input logic [3:0] r);
      busA.voice_ready = r;
      busB.voice_ready = r;
   endtask

   // Wait a bounded number of cycles for dutA's strobe, counting ticks.
   task automatic waitStrobe(input int limit);
      while (!busA.new_sample_ready && count < limit) begin
         tick();
         count++;
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      reset  = 1'b1;
      applyStimulus(1'b0, 6'd0, 6'd0, 4'b0000);
      setBeat(1'b0);
      setRequest(1'b0);
      setSamples(16'sd0, 16'sd0, 16'sd0, 16'sd0);
      setReady(4'b0000);
      repeat (3) tick();

      checkOutput("reset voice_load", busA.voice_load, 0);
      checkOutput("reset active_voices", busA.active_voices, 0);
      checkOutput("reset sample_out", $signed(busA.sample_out), 0);
      checkOutput("reset new_sample_ready", busA.new_sample_ready, 0);
      checkOutput("reset note_dropped", busB.note_dropped, 0);
      reset = 1'b0;
      tick();

      $display("[TB] single load into idle pool");
      applyStimulus(1'b1, 6'd10, 6'd8, 4'b0000);
      tick();
      applyStimulus(1'b0, 6'd0, 6'd0, 4'b0000);
      checkOutput("load1 voice_load", busA.voice_load, 1);
      checkOutput("load1 voice_note", busA.voice_note, 10);
      checkOutput("load1 voice_duration", busA.voice_duration, 8);
      checkOutput("load1 dutB voice_load", busB.voice_load, 1);
      tick();
      checkOutput("load1 strobe width", busA.voice_load, 0);
      repeat (6) tick();
      checkOutput("reservation expiry", busA.active_voices, 0);

      $display("[TB] back-to-back loads");
      for (int k = 0; k < 4; k++) begin
         applyStimulus(1'b1, 6'(k + 1), 6'd2, 4'b0000);
         tick();
         checkOutput($sformatf("b2b voice_load %0d", k), busA.voice_load, 1 << k);
      end
      applyStimulus(1'b0, 6'd0, 6'd0, 4'b0000);
      checkOutput("b2b active_voices", busA.active_voices, 4);
      repeat (6) tick();

      $display("[TB] voice stealing with ages 5,9,9,2");
      applyStimulus(1'b0, 6'd0, 6'd0, 4'b1111);
      setBeat(1'b1);
      repeat (2) tick();
      applyStimulus(1'b0, 6'd0, 6'd0, 4'b0111);
      repeat (3) tick();
      applyStimulus(1'b0, 6'd0, 6'd0, 4'b0110);
      repeat (4) tick();
      setBeat(1'b0);
      applyStimulus(1'b1, 6'd20, 6'd4, 4'b1111);
      tick();
      applyStimulus(1'b0, 6'd0, 6'd0, 4'b1111);
      checkOutput("steal oldest tie low index", busA.voice_load, 4'b0010);
      checkOutput("steal voice_note", busA.voice_note, 20);
      checkOutput("full drop note_dropped", busB.note_dropped, 1);
      checkOutput("full drop voice_load", busB.voice_load, 0);
      checkOutput("full active_voices", busA.active_voices, 4);
      tick();
      checkOutput("note_dropped width", busB.note_dropped, 0);
      applyStimulus(1'b1, 6'd21, 6'd4, 4'b1111);
      tick();
      checkOutput("steal after age reset", busA.voice_load, 4'b0100);
      tick();
      checkOutput("steal third", busA.voice_load, 4'b0001);
      tick();
      checkOutput("steal fourth", busA.voice_load, 4'b1000);
      applyStimulus(1'b0, 6'd0, 6'd0, 4'b0000);
      repeat (6) tick();

      $display("[TB] full mix 1000,2000,-500,300");
      setRequest(1'b1);
      tick();
      setRequest(1'b0);
      setSamples(16'sd1000, 16'sd2000, -16'sd500, 16'sd300);
      setReady(4'b1111);
      tick();
      setReady(4'b0000);
      count = 1;
      waitStrobe(20);
      checkOutput("mix strobe latency", count, 6);
      checkOutput("mix sample_out shift2", $signed(busA.sample_out), 700);
      checkOutput("mix sample_out shift0", $signed(busB.sample_out), 2800);
      checkOutput("mix dutB strobe", busB.new_sample_ready, 1);
      tick();
      checkOutput("strobe width", busA.new_sample_ready, 0);

      $display("[TB] positive saturation");
      setRequest(1'b1);
      tick();
      setRequest(1'b0);
      setSamples(16'sd32767, 16'sd32767, 16'sd32767, 16'sd32767);
      setReady(4'b1111);
      tick();
      setReady(4'b0000);
      count = 1;
      waitStrobe(20);
      checkOutput("pos max shift2", $signed(busA.sample_out), 32767);
      checkOutput("pos saturation", $signed(busB.sample_out), 32767);

      $display("[TB] negative saturation");
      tick();
      setRequest(1'b1);
      tick();
      setRequest(1'b0);
      setSamples(-16'sd32768, -16'sd32768, -16'sd32768, -16'sd32768);
      setReady(4'b1111);
      tick();
      setReady(4'b0000);
      count = 1;
      waitStrobe(20);
      checkOutput("neg min shift2", $signed(busA.sample_out), -32768);
      checkOutput("neg saturation", $signed(busB.sample_out), -32768);

      $display("[TB] voice 3 never ready");
      tick();
      setRequest(1'b1);
      tick();
      setRequest(1'b0);
      count = 1;
      setSamples(16'sd400, 16'sd800, 16'sd1200, 16'sd4000);
      setReady(4'b0111);
      tick();
      count++;
      setReady(4'b0000);
      waitStrobe(120);
      checkOutput("timeout strobe seen", busA.new_sample_ready, 1);
      checkOutput("timeout not early", (count >= 64) ? 1 : 0, 1);
      checkOutput("timeout not late", (count <= 72) ? 1 : 0, 1);
      checkOutput("timeout sample shift2", $signed(busA.sample_out), 600);
      checkOutput("timeout sample shift0", $signed(busB.sample_out), 2400);

      $display("[TB] reset during SUM");
      tick();
      setRequest(1'b1);
      tick();
      setRequest(1'b0);
      setSamples(16'sd1000, 16'sd2000, -16'sd500, 16'sd300);
      setReady(4'b1111);
      tick();
      setReady(4'b0000);
      tick();
      reset = 1'b1;
      seen  = 1'b0;
      repeat (2) tick();
      reset = 1'b0;
      for (int k = 0; k < 10; k++) begin
         if (busA.new_sample_ready || busB.new_sample_ready) seen = 1'b1;
         tick();
      end
      checkOutput("abort no strobe", seen, 0);
      checkOutput("abort sample_out A", $signed(busA.sample_out), 0);
      checkOutput("abort sample_out B", $signed(busB.sample_out), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
